// File: rtl/wb_write_arbiter.sv
// Register-file write-port owner: ALU results take priority, load returns are
// formatted on entry and buffered in a small FIFO that drains on ALU-idle cycles.
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_result,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [4:0]    ld_rd,
    input  logic [2:0]    ld_funct3,
    input  logic [1:0]    ld_addr_lo,
    input  logic [31:0]   ld_rdata,
    output logic          we3,
    output logic [4:0]    a3,
    output logic [31:0]   wd3,
    output logic [CW-1:0] ld_count,
    output logic [31:0]   pend_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][4:0]  fifo_rd;
    logic [DEPTH-1:0][31:0] fifo_data;
    logic [DEPTH-1:0]       fifo_vld;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   src_fifo;
    logic                   alu_go, push, pop;
    logic [31:0]            ld_fmt;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;

    assign ld_ready = (ld_count < CW'(DEPTH));
    assign alu_go   = alu_valid && (alu_rd != 5'd0);
    assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign pop      = !alu_go && (ld_count != '0);

    // Formatting happens before the FIFO so the pop path is a plain mux.
    always_comb begin
        ld_byte = ld_rdata[8*ld_addr_lo +: 8];
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = ld_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd   <= '0;
            fifo_data <= '0;
            fifo_vld  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ld_count  <= '0;
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= ld_rd;
                fifo_data[wr_ptr] <= ld_fmt;
                wr_ptr            <= PW'((int'(wr_ptr) + 1) % DEPTH);
            end
            if (pop) rd_ptr <= PW'((int'(rd_ptr) + 1) % DEPTH);
            // Push and pop never target the same slot: push needs count<DEPTH.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr == PW'(i))     fifo_vld[i] <= 1'b1;
                else if (pop && rd_ptr == PW'(i)) fifo_vld[i] <= 1'b0;
            end
            if (push && !pop)      ld_count <= ld_count + 1'b1;
            else if (pop && !push) ld_count <= ld_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            src_fifo <= 1'b0;
        end else if (alu_go) begin
            we3      <= 1'b1;
            a3       <= alu_rd;
            wd3      <= alu_result;
            src_fifo <= 1'b0;
        end else if (pop) begin
            we3      <= 1'b1;
            a3       <= fifo_rd[rd_ptr];
            wd3      <= fifo_data[rd_ptr];
            src_fifo <= 1'b1;
        end else begin
            we3      <= 1'b0;
            src_fifo <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (fifo_vld[i]) pend_mask[fifo_rd[i]] = 1'b1;
        if (we3 && src_fifo) pend_mask[a3] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: format table plus priority, backpressure,
// push/pop overlap, rd=0 discard and mid-stream reset sequences.
module tb_wb_write_arbiter;
    logic        clk = 0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [1:0]  ld_count;
    logic [31:0] pend_mask;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.DEPTH(2), .CW(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
        .we3(we3), .a3(a3), .wd3(wd3), .ld_count(ld_count), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string name, input logic w, input logic [4:0] a, input logic [31:0] d);
        chk({name, ".we3"}, {31'd0, we3}, {31'd0, w});
        if (w) begin
            chk({name, ".a3"}, {27'd0, a3}, {27'd0, a});
            chk({name, ".wd3"}, wd3, d);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [31:0] exp;
    } fmt_vec_t;

    fmt_vec_t vecs[10];

    initial begin
        vecs[0] = '{3'b000, 2'd1, 32'h0000007F};
        vecs[1] = '{3'b000, 2'd2, 32'hFFFFFFFF};
        vecs[2] = '{3'b100, 2'd3, 32'h00000080};
        vecs[3] = '{3'b001, 2'd2, 32'hFFFF80FF};
        vecs[4] = '{3'b101, 2'd0, 32'h00007F01};
        vecs[5] = '{3'b010, 2'd3, 32'h80FF7F01};
        vecs[6] = '{3'b000, 2'd0, 32'h00000001};
        vecs[7] = '{3'b001, 2'd3, 32'hFFFF80FF};
        vecs[8] = '{3'b101, 2'd2, 32'h000080FF};
        vecs[9] = '{3'b011, 2'd1, 32'h80FF7F01};

        alu_valid = 0; alu_rd = 0; alu_result = 0;
        ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_rdata = 0;
        rst = 1;
        #3;
        chk("rst.we3", {31'd0, we3}, 0);
        chk("rst.a3", {27'd0, a3}, 0);
        chk("rst.wd3", wd3, 0);
        chk("rst.count", {30'd0, ld_count}, 0);
        chk("rst.pend", pend_mask, 0);
        tick();
        rst = 0;
        tick();
        chk("rst.ready", {31'd0, ld_ready}, 1);

        // ALU path
        alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
        tick();
        port("alu", 1, 5, 32'hDEADBEEF);
        alu_rd = 0; alu_result = 32'h12345678;
        tick();
        chk("alu0.we3", {31'd0, we3}, 0);
        chk("alu0.a3hold", {27'd0, a3}, 5);
        chk("alu0.wd3hold", wd3, 32'hDEADBEEF);
        alu_valid = 0;

        // Load formatting table
        foreach (vecs[i]) begin
            ld_valid = 1; ld_rd = 5'd3; ld_rdata = 32'h80FF7F01;
            ld_funct3 = vecs[i].f3; ld_addr_lo = vecs[i].addr;
            tick();
            ld_valid = 0;
            chk($sformatf("fmt%0d.pend", i), pend_mask, 32'h8);
            tick();
            port($sformatf("fmt%0d", i), 1, 3, vecs[i].exp);
        end
        tick();
        chk("fmt.idle", {31'd0, we3}, 0);
        chk("fmt.pend0", pend_mask, 0);

        // Priority and backpressure
        ld_funct3 = 3'b010; ld_addr_lo = 0;
        alu_valid = 1; alu_rd = 1; alu_result = 32'h111;
        ld_valid = 1; ld_rd = 7; ld_rdata = 32'h77;
        tick();
        port("pri1", 1, 1, 32'h111);
        chk("pri1.count", {30'd0, ld_count}, 1);
        chk("pri1.pend", pend_mask, 32'h80);
        alu_rd = 2; alu_result = 32'h222;
        ld_rd = 8; ld_rdata = 32'h88;
        tick();
        port("pri2", 1, 2, 32'h222);
        chk("pri2.count", {30'd0, ld_count}, 2);
        chk("pri2.ready", {31'd0, ld_ready}, 0);
        chk("pri2.pend", pend_mask, 32'h180);
        alu_rd = 4; alu_result = 32'h444;
        ld_rd = 9; ld_rdata = 32'h99;
        tick();
        port("pri3", 1, 4, 32'h444);
        chk("pri3.count", {30'd0, ld_count}, 2);
        chk("pri3.pend", pend_mask, 32'h180);
        ld_valid = 0; alu_valid = 0;
        tick();
        port("drain1", 1, 7, 32'h77);
        chk("drain1.count", {30'd0, ld_count}, 1);
        chk("drain1.pend", pend_mask, 32'h180);
        tick();
        port("drain2", 1, 8, 32'h88);
        chk("drain2.count", {30'd0, ld_count}, 0);
        chk("drain2.pend", pend_mask, 32'h100);
        tick();
        chk("drain3.we3", {31'd0, we3}, 0);
        chk("drain3.pend", pend_mask, 0);

        // Simultaneous push/pop
        ld_valid = 1; ld_rd = 10; ld_rdata = 32'hA;
        tick();
        chk("pp1.count", {30'd0, ld_count}, 1);
        chk("pp1.we3", {31'd0, we3}, 0);
        ld_rd = 11; ld_rdata = 32'hB;
        tick();
        port("pp2", 1, 10, 32'hA);
        chk("pp2.count", {30'd0, ld_count}, 1);
        chk("pp2.pend", pend_mask, 32'hC00);
        ld_valid = 0;
        tick();
        port("pp3", 1, 11, 32'hB);
        chk("pp3.count", {30'd0, ld_count}, 0);
        chk("pp3.pend", pend_mask, 32'h800);
        tick();
        chk("pp4.pend", pend_mask, 0);

        // Load to x0 is discarded
        ld_valid = 1; ld_rd = 0; ld_rdata = 32'hFFFF;
        #1;
        chk("x0.ready", {31'd0, ld_ready}, 1);
        tick();
        ld_valid = 0;
        chk("x0.count", {30'd0, ld_count}, 0);
        tick();
        chk("x0.we3", {31'd0, we3}, 0);
        chk("x0.pend", pend_mask, 0);

        // Reset mid-operation
        alu_valid = 1; alu_rd = 3; alu_result = 32'h333;
        ld_valid = 1; ld_rd = 12; ld_rdata = 32'hC;
        tick();
        ld_rd = 13; ld_rdata = 32'hD;
        tick();
        chk("mrst.pre.count", {30'd0, ld_count}, 2);
        chk("mrst.pre.we3", {31'd0, we3}, 1);
        #2;
        rst = 1;
        #1;
        chk("mrst.we3", {31'd0, we3}, 0);
        chk("mrst.count", {30'd0, ld_count}, 0);
        chk("mrst.pend", pend_mask, 0);
        alu_valid = 0; ld_valid = 0;
        tick();
        rst = 0;
        tick();
        chk("mrst.ready", {31'd0, ld_ready}, 1);
        chk("mrst.idle", {31'd0, we3}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side producer for the RV32I register file: owns the single write port (we3/a3/wd3) and merges two result sources into it.
- Sources: single-cycle ALU results, which have priority and never stall, and memory load returns, which are buffered in a small FIFO with valid/ready.
- Formats loads (LB/LH/LW/LBU/LHU) before write-back.
- Exports a per-register pending mask so the hazard unit can stall readers of in-flight load destinations.

Parameters:
- DEPTH, 2, load-return FIFO entries; power of two, >=2.
- CW, 2, width of ld_count; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  FIFO can accept load return
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type
- ld_addr_lo  in  2  load byte address [1:0]
- ld_rdata  in  32  raw aligned memory word
- we3  out  1  register-file write enable (registered)
- a3  out  5  register-file write address (registered)
- wd3  out  32  register-file write data (registered)
- ld_count  out  CW  FIFO occupancy
- pend_mask  out  32  bit r=1 while a load to xr is buffered or on the write port

Behaviour:
- Reset (asynchronous, immediate): we3=0, a3=0, wd3=0, FIFO empty, ld_count=0, pend_mask=0, internal output-source flag=ALU.
- ld_ready = (ld_count < DEPTH). Depends only on registered count; no same-cycle pop-through when full.
- Load push: on ld_valid && ld_ready at an edge.
  - ld_rd=0: handshake completes, entry discarded, no push.
  - Otherwise the formatted data is pushed with rd.
- Load formatting is done at push time:
  - LB (000): byte at ld_addr_lo, sign-extended.
  - LH (001): half at ld_addr_lo[1], sign-extended; ld_addr_lo[0] ignored.
  - LW (010): ld_rdata as-is; addr ignored.
  - LBU (100): byte, zero-extended.
  - LHU (101): half, zero-extended.
  - Any other funct3 is treated as LW.
- Write-port selection, per edge, evaluated in order:
  1. alu_valid && alu_rd!=0: we3<=1, a3<=alu_rd, wd3<=alu_result. FIFO head is held.
  2. Otherwise, if FIFO is non-empty: pop head; we3<=1, a3/wd3<=head.
  3. Otherwise: we3<=0; a3/wd3 hold their previous values.
- alu_valid with alu_rd=0 counts as idle, so the FIFO may drain that cycle.
- Latency:
  - ALU result sampled at edge k → we3 high in cycle k..k+1 → register file writes at edge k+1.
  - Load accepted at edge k → earliest pop at edge k+1 → written at edge k+2.
  - No bypass from ld_* to the write port.
- Simultaneous push and pop: allowed; count unchanged. Pointers wrap modulo DEPTH.
- Ordering: loads leave in acceptance order. An ALU write and a buffered load to the same rd land in arbitration order; the hazard unit prevents WAW using pend_mask.
- pend_mask:
  - OR of one-hot(rd) over valid FIFO entries, plus one-hot(a3) if we3=1 and the current output came from the FIFO.
  - Combinational from registered state; bit 0 is always 0.
- Starvation: the FIFO drains only on ALU-idle cycles, by design. Upstream bubbles come from the pend_mask stalls.
- Reset mid-operation: buffered loads are dropped, we3 drops immediately, ld_ready=1 after rst deasserts.

Test Plan:
- Reset: assert rst mid-stream with 2 loads buffered and we3=1 → we3=0, ld_count=0, pend_mask=0 immediately; ld_ready=1 after release.
- ALU path: alu_valid=1, rd=5, result=0xDEADBEEF → next cycle we3=1, a3=5, wd3=0xDEADBEEF. With rd=0 → we3=0.
- Load formatting: ld_rdata=0x80FF7F01 with each funct3/addr combination:
  - LB@1 → 0x0000007F; LB@2 → 0xFFFFFFFF; LBU@3 → 0x00000080.
  - LH@2 → 0xFFFF80FF; LHU@0 → 0x00007F01; LW → 0x80FF7F01.
- Priority and backpressure:
  - Push loads to x7 and x8 while alu_valid=1 continuously → ld_ready=0 after 2, pend_mask bits 7 and 8 set, only ALU writes appear.
  - Drop alu_valid → x7 written, then x8; count decreases 2→1→0.
- Simultaneous push/pop at count=1 with ALU idle → count stays 1, FIFO order preserved, pend_mask tracks exactly.
- Load with ld_rd=0 → ld_ready handshake completes, count unchanged, no write.
